// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, default timing
// and the row pattern seen when no key in the driven column is pressed.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } kp_state_e;

  localparam int DEF_STABLE_CYCLES = 13;
  localparam int DEF_DWELL_CYCLES  = 4;

  localparam logic [3:0] ROWS_RELEASED = 4'hF;

  // Index of the lowest-numbered active-low row; row 0 has highest priority.
  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event signals. The scanner takes the slave view;
// the keypad/consumer side takes the master view.
interface keypad_scanner_if;

  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_HELD;

  modport master (
    output ROW,
    input  COL,
    input  KEY_CODE,
    input  KEY_VALID,
    input  KEY_HELD
  );

  modport slave (
    input  ROW,
    output COL,
    output KEY_CODE,
    output KEY_VALID,
    output KEY_HELD
  );

endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous row returns. Resets to the
// all-released pattern so a reset never looks like a key press.
module row_sync
  import keypad_pkg::*;
(
  input  logic       DEBOUNCE_CLK,
  input  logic       RESET,
  input  logic [3:0] row_in,
  output logic [3:0] row_s
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  // Next value of each synchronizer stage.
  always_comb begin
    meta_d = row_in;
    sync_d = meta_q;
  end

  // Synchronizer flops, asynchronously forced to all-released.
  always_ff @(posedge DEBOUNCE_CLK or negedge RESET) begin
    if (!RESET) begin
      meta_q <= ROWS_RELEASED;
      sync_q <= ROWS_RELEASED;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_s = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns, debounces the first key found and
// then tracks only that key until it is cleanly released. All outputs are
// registered; ROW reaches the FSM only through the synchronizer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int DWELL_CYCLES  = DEF_DWELL_CYCLES
) (
  input  logic               DEBOUNCE_CLK,
  input  logic               RESET,
  keypad_scanner_if.slave    kp
);

  localparam int CNT_MAX = (STABLE_CYCLES > DWELL_CYCLES) ? STABLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

  // Counters stop at their ceiling instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_SAT) ? v : v + 1'b1;
  endfunction

  logic [3:0]       row_s;

  kp_state_e        state_q,     state_d;
  logic [1:0]       col_idx_q,   col_idx_d;
  logic [1:0]       row_idx_q,   row_idx_d;
  logic [CNT_W-1:0] dwell_q,     dwell_d;
  logic [CNT_W-1:0] stable_q,    stable_d;
  logic [3:0]       col_q,       col_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q,  key_held_d;
  logic             row_bit_low;

  row_sync u_row_sync (
    .DEBOUNCE_CLK (DEBOUNCE_CLK),
    .RESET        (RESET),
    .row_in       (kp.ROW),
    .row_s        (row_s)
  );

  // Next-state and next-output logic for the scan/debounce FSM.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    stable_d    = stable_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    row_bit_low = ~row_s[row_idx_q];

    case (state_q)
      SCAN: begin
        if (dwell_q >= DWELL_LAST) begin
          dwell_d = '0;
          if (row_s == ROWS_RELEASED) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = low_row_idx(row_s);
            stable_d  = '0;
            state_d   = CONFIRM;
          end
        end else begin
          dwell_d = sat_inc(dwell_q);
        end
      end

      CONFIRM: begin
        if (row_bit_low) begin
          if (stable_q >= STABLE_LAST) begin
            key_valid_d = 1'b1;
            key_code_d  = {row_idx_q, col_idx_q};
            stable_d    = '0;
            state_d     = HELD;
          end else begin
            stable_d = sat_inc(stable_q);
          end
        end else begin
          // Bounce: rescan the same column from a fresh dwell.
          stable_d = '0;
          dwell_d  = '0;
          state_d  = SCAN;
        end
      end

      HELD: begin
        if (!row_bit_low) begin
          stable_d = '0;
          state_d  = RELEASE;
        end
      end

      RELEASE: begin
        if (row_bit_low) begin
          stable_d = '0;
          state_d  = HELD;
        end else if (stable_q >= STABLE_LAST) begin
          stable_d  = '0;
          dwell_d   = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else begin
          stable_d = sat_inc(stable_q);
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    col_d      = ~(4'b0001 << col_idx_d);
    key_held_d = (state_d == HELD) || (state_d == RELEASE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge DEBOUNCE_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      dwell_q     <= '0;
      stable_q    <= '0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      stable_q    <= stable_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.COL       = col_q;
  assign kp.KEY_CODE  = key_code_q;
  assign kp.KEY_VALID = key_valid_q;
  assign kp.KEY_HELD  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model turns a set of pressed
// keys into ROW from the driven COL, and a behavioural model predicts every
// output cycle by cycle from the row samples the scanner should see.
module tb_keypad_scanner;

  localparam int STABLE = 13;
  localparam int DWELL  = 4;

  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD    = 2;
  localparam int M_RELEASE = 3;

  logic clk;
  logic rst_n;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .STABLE_CYCLES (STABLE),
    .DWELL_CYCLES  (DWELL)
  ) dut (
    .DEBOUNCE_CLK (clk),
    .RESET        (rst_n),
    .kp           (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int cyc;
  int n_valid_obs;
  int last_valid_cyc;

  // Keypad: bit r*4+c set means the key at row r, column c is pressed.
  logic [15:0] keys;

  // Behavioural model state.
  int         m_mode;
  int         m_col;
  int         m_row;
  int         m_age;
  int         m_run;
  logic [3:0] m_code;
  bit         m_valid;
  logic [3:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] keys_to_row(input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && !col[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_mode  = M_SCAN;
    m_col   = 0;
    m_row   = 0;
    m_age   = 0;
    m_run   = 0;
    m_code  = 4'h0;
    m_valid = 1'b0;
    hist.delete();
    hist.push_back(4'hF);
    hist.push_back(4'hF);
  endtask

  // One clock edge of the model; the scanner sees ROW from two edges ago.
  task automatic model_step(input logic [3:0] row_in);
    logic [3:0] seen;
    bit         low;
    seen = hist.pop_front();
    hist.push_back(row_in);
    m_valid = 1'b0;
    low = (seen[m_row] == 1'b0);
    case (m_mode)
      M_SCAN: begin
        m_age++;
        if (m_age == DWELL) begin
          m_age = 0;
          if (seen == 4'hF) begin
            m_col = (m_col + 1) % 4;
          end else begin
            for (int r = 3; r >= 0; r--) if (seen[r] == 1'b0) m_row = r;
            m_run  = 0;
            m_mode = M_CONFIRM;
          end
        end
      end
      M_CONFIRM: begin
        if (low) begin
          m_run++;
          if (m_run == STABLE) begin
            m_valid = 1'b1;
            m_code  = 4'(m_row * 4 + m_col);
            m_mode  = M_HELD;
          end
        end else begin
          m_age  = 0;
          m_mode = M_SCAN;
        end
      end
      M_HELD: begin
        if (!low) begin
          m_run  = 0;
          m_mode = M_RELEASE;
        end
      end
      default: begin
        if (low) begin
          m_mode = M_HELD;
        end else begin
          m_run++;
          if (m_run == STABLE) begin
            m_col  = (m_col + 1) % 4;
            m_age  = 0;
            m_mode = M_SCAN;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    logic [3:0] exp_col;
    kp.ROW = keys_to_row(kp.COL);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(kp.ROW);
    #1;
    cyc++;
    exp_col = 4'hF ^ (4'h1 << m_col);
    chk("COL",       kp.COL,       exp_col);
    chk("KEY_CODE",  kp.KEY_CODE,  m_code);
    chk("KEY_VALID", kp.KEY_VALID, m_valid);
    chk("KEY_HELD",  kp.KEY_HELD,  (m_mode == M_HELD) || (m_mode == M_RELEASE));
    if (kp.KEY_VALID === 1'b1) begin
      n_valid_obs++;
      if (last_valid_cyc >= 0)
        chk("valid_spacing", (cyc - last_valid_cyc) >= (2*STABLE + 2), 1);
      last_valid_cyc = cyc;
    end
  endtask

  task automatic wait_mode(input int mode, input int budget);
    for (int i = 0; i < budget && m_mode != mode; i++) tick();
    if (m_mode != mode) chk("wait_mode_timeout", m_mode, mode);
  endtask

  task automatic wait_held_low(input int budget);
    for (int i = 0; i < budget && kp.KEY_HELD !== 1'b0; i++) tick();
    if (kp.KEY_HELD !== 1'b0) chk("held_release_timeout", kp.KEY_HELD, 0);
  endtask

  // Assert RESET between edges and check outputs respond without a clock.
  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_col"},   kp.COL,       4'hE);
    chk({tag, "_code"},  kp.KEY_CODE,  4'h0);
    chk({tag, "_valid"}, kp.KEY_VALID, 0);
    chk({tag, "_held"},  kp.KEY_HELD,  0);
    repeat (3) tick();
    #2;
    rst_n = 1'b1;
    last_valid_cyc = -1;
  endtask

  initial begin
    int v0;
    int dur;
    bit bouncy;
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    n_valid_obs = 0;
    last_valid_cyc = -1;
    keys = 16'h0;
    kp.ROW = 4'hF;
    rst_n = 1'b0;
    model_reset();

    #12;
    chk("rst_col",   kp.COL,       4'hE);
    chk("rst_code",  kp.KEY_CODE,  4'h0);
    chk("rst_valid", kp.KEY_VALID, 0);
    chk("rst_held",  kp.KEY_HELD,  0);
    #1;
    rst_n = 1'b1;

    // Idle scan.
    v0 = n_valid_obs;
    repeat (64) tick();
    chk("idle_valid_count", n_valid_obs - v0, 0);

    // Row 1 / column 2 held.
    v0 = n_valid_obs;
    keys = 16'h1 << (1*4 + 2);
    repeat (40) tick();
    chk("k6_valid_count", n_valid_obs - v0, 1);
    chk("k6_code", kp.KEY_CODE, 4'h6);
    chk("k6_held", kp.KEY_HELD, 1);
    chk("k6_col",  kp.COL, 4'b1011);
    keys = 16'h0;
    wait_held_low(40);
    chk("k6_next_col", kp.COL, 4'b0111);
    repeat (10) tick();

    // Bouncing row 0 / column 0, then a clean press.
    v0 = n_valid_obs;
    for (int i = 0; i < 72; i++) begin
      keys = ((i % 6) < 5) ? 16'h1 : 16'h0;
      tick();
    end
    chk("bounce_valid_count", n_valid_obs - v0, 0);
    keys = 16'h1;
    repeat (40) tick();
    chk("k0_valid_count", n_valid_obs - v0, 1);
    chk("k0_code", kp.KEY_CODE, 4'h0);

    // Release bounce keeps the key held; a clean release resumes scanning.
    v0 = n_valid_obs;
    keys = 16'h0;
    repeat (3) tick();
    keys = 16'h1;
    repeat (6) tick();
    chk("relbounce_held", kp.KEY_HELD, 1);
    chk("relbounce_valid_count", n_valid_obs - v0, 0);
    keys = 16'h0;
    wait_held_low(40);
    chk("k0_next_col", kp.COL, 4'b1101);
    repeat (10) tick();

    // Rows 2 and 3 together on column 3: row 2 wins; row 3 ignored while held.
    v0 = n_valid_obs;
    keys = (16'h1 << 11) | (16'h1 << 15);
    repeat (40) tick();
    chk("kB_valid_count", n_valid_obs - v0, 1);
    chk("kB_code", kp.KEY_CODE, 4'hB);
    keys = 16'h1 << 11;
    repeat (5) tick();
    keys = (16'h1 << 11) | (16'h1 << 15) | 16'h1;
    repeat (10) tick();
    chk("kB_extra_valid_count", n_valid_obs - v0, 1);
    chk("kB_extra_code", kp.KEY_CODE, 4'hB);
    chk("kB_extra_held", kp.KEY_HELD, 1);
    keys = 16'h0;
    repeat (40) tick();

    // Reset during CONFIRM, key kept down: needs a fresh confirmation.
    keys = 16'h1 << (2*4 + 1);
    wait_mode(M_CONFIRM, 60);
    repeat (5) tick();
    async_reset_check("rst_confirm");
    v0 = n_valid_obs;
    wait_mode(M_HELD, 80);
    chk("rst_confirm_revalid", n_valid_obs - v0, 1);
    chk("rst_confirm_code", kp.KEY_CODE, 4'h9);
    repeat (5) tick();

    // Reset during HELD.
    async_reset_check("rst_held");
    wait_mode(M_HELD, 80);
    keys = 16'h0;
    repeat (40) tick();

    // Randomized presses, releases and bounce.
    for (int ep = 0; ep < 60; ep++) begin
      case ($urandom_range(0, 3))
        0:       keys = 16'h0;
        1:       keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: keys = 16'h1 << $urandom_range(0, 15);
      endcase
      bouncy = ($urandom_range(0, 2) == 0);
      dur = $urandom_range(3, 60);
      for (int c = 0; c < dur; c++) begin
        if (bouncy && $urandom_range(0, 4) == 0)
          keys = keys ^ (16'h1 << $urandom_range(0, 15));
        tick();
      end
    end
    keys = 16'h0;
    repeat (40) tick();
    chk("final_held", kp.KEY_HELD, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter STABLE_CYCLES, default 13, consecutive identical samples required to accept a press or release.
REQ-002 Parameter DWELL_CYCLES, default 4, cycles each column is driven while scanning.
REQ-003 DEBOUNCE_CLK  input  1  scan/debounce clock; all state changes on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 ROW  input  4  keypad row returns, active-low (external pull-ups), asynchronous to DEBOUNCE_CLK.
REQ-006 COL  output  4  column drives, active-low, exactly one bit low at any time.
REQ-007 KEY_CODE  output  4  accepted key index = row*4 + col; holds last accepted value.
REQ-008 KEY_VALID  output  1  single-cycle pulse on acceptance of a new press.
REQ-009 KEY_HELD  output  1  level, high while an accepted key is held or its release is being debounced.

Function
REQ-010 ROW shall pass through a 2-flop synchronizer; all decisions use the synchronized value ROW_S (2-cycle latency).
REQ-011 FSM states shall be SCAN, CONFIRM, HELD, RELEASE.
REQ-012 SCAN: column index COL_IDX (2 bits) drives COL = ~(1<<COL_IDX); ROW_S sampled on the last (DWELL_CYCLES-th) dwell cycle.
REQ-013 SCAN: sampled ROW_S == 4'hF -> COL_IDX increments, wrapping 3->0; dwell counter restarts.
REQ-014 SCAN: sampled ROW_S != 4'hF -> latch COL_IDX and lowest-index low row (priority encode, row 0 highest), clear stable counter, enter CONFIRM.
REQ-015 CONFIRM: column held; each cycle the latched row bit is low increments stable counter; counter value STABLE_CYCLES-1 reached with bit low -> KEY_VALID=1 one cycle, KEY_CODE updated in same cycle, enter HELD.
REQ-016 CONFIRM: latched row bit high in any cycle -> counter cleared, return to SCAN on same COL_IDX, no KEY_VALID.
REQ-017 HELD: KEY_HELD=1, column held; latched row bit high -> clear counter, enter RELEASE.
REQ-018 RELEASE: latched row bit low -> return to HELD, no new KEY_VALID; STABLE_CYCLES consecutive high samples -> enter SCAN with COL_IDX+1 (wrap), KEY_HELD=0.
REQ-019 Additional keys pressed in HELD/RELEASE shall be ignored; only the latched row/column is monitored.
REQ-020 Stable and dwell counters shall saturate, never wrap; width sized for max(STABLE_CYCLES, DWELL_CYCLES).
REQ-021 KEY_VALID shall never assert in two consecutive cycles; minimum spacing 2*STABLE_CYCLES+2 cycles.

Reset
REQ-022 RESET low shall asynchronously force: state SCAN, COL_IDX 0, COL 4'b1110, KEY_CODE 4'h0, KEY_VALID 0, KEY_HELD 0, counters 0, synchronizer flops 4'hF.
REQ-023 Reset deassertion mid-press shall require a full new CONFIRM sequence before KEY_VALID.
REQ-024 Outputs shall be registered; no combinational path ROW -> any output.

Structure
REQ-025 Package keypad_pkg shall hold the state enumeration, default STABLE_CYCLES/DWELL_CYCLES, and the all-released constant 4'hF.
REQ-026 Sub-module row_sync (4-bit 2-flop synchronizer, async active-low reset to 4'hF) shall be instantiated once.

Verification
REQ-027 Reset then ROW=4'hF for 64 cycles -> COL cycles 1110,1101,1011,0111 every 4 cycles, KEY_VALID never high.
REQ-028 Hold row 1 low while COL=1011 (col 2) for 40 cycles -> exactly one KEY_VALID, KEY_CODE=4'h6, KEY_HELD high, COL frozen at 1011.
REQ-029 Row 0 bounces (low 5, high 1, repeated) during col 0 -> no KEY_VALID; then stable low 20 cycles -> one KEY_VALID, KEY_CODE=4'h0.
REQ-030 Held key released with 3-cycle bounce high then low -> KEY_HELD stays 1, no second KEY_VALID; release stable 13+ cycles -> KEY_HELD=0, scan resumes at next column.
REQ-031 Rows 2 and 3 low together on col 3 -> KEY_CODE=4'hB (row 2 wins); row 3 later alone while held -> ignored.
REQ-032 RESET low during CONFIRM and HELD -> all outputs at reset values within same cycle; KEY_VALID only after fresh 13-cycle confirmation.
